// File: rtl/mem_fetch_unit_if.sv
// Byte-wide request/acknowledge read bus between the fetch unit and memory.
interface mem_fetch_unit_if;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_addr, output mem_req, input mem_ack, input mem_rdata);
  modport slave  (input mem_addr, input mem_req, output mem_ack, output mem_rdata);
endinterface

// File: rtl/mem_fetch_unit.sv
// Memory fetch / register-load stage. Accepts an address-select code and a
// destination mask from the control unit, performs one byte read on the
// memory bus and writes the byte into every selected CPU register.
module mem_fetch_unit (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       mem_read,
  input  logic [15:0]      fetch,
  input  logic             pc_inc,
  output logic             busy,
  mem_fetch_unit_if.master bus,
  output logic [15:0]      PC,
  output logic [15:0]      AR,
  output logic [15:0]      X,
  output logic [15:0]      Y,
  output logic [15:0]      IR,
  output logic [7:0]       T,
  output logic [7:0]       DP,
  output logic [7:0]       A,
  output logic [7:0]       B
);

  typedef enum logic {IDLE, REQ} state_e;

  localparam int unsigned M_IR  = 0;
  localparam int unsigned M_ARL = 1;
  localparam int unsigned M_ARH = 2;
  localparam int unsigned M_T   = 3;
  localparam int unsigned M_A   = 4;
  localparam int unsigned M_B   = 5;
  localparam int unsigned M_XL  = 6;
  localparam int unsigned M_XH  = 7;
  localparam int unsigned M_YL  = 8;
  localparam int unsigned M_YH  = 9;
  localparam int unsigned M_DP  = 10;

  state_e      state_q, state_d;
  logic [10:0] mask_q, mask_d;
  logic [15:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic [15:0] pc_q, pc_d, ar_q, ar_d, x_q, x_d, y_q, y_d, ir_q, ir_d;
  logic [7:0]  t_q, t_d, dp_q, dp_d, a_q, a_d, b_q, b_d;
  logic        start;

  // Destination bits above DP carry no meaning for this stage.
  logic unused_fetch_hi;
  assign unused_fetch_hi = ^fetch[15:11];

  // Next-state, address select and register-load logic.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    addr_d  = addr_q;
    req_d   = req_q;
    pc_d    = pc_q;
    ar_d    = ar_q;
    x_d     = x_q;
    y_d     = y_q;
    ir_d    = ir_q;
    t_d     = t_q;
    dp_d    = dp_q;
    a_d     = a_q;
    b_d     = b_q;
    start   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pc_inc) pc_d = pc_q + 16'd1;
        // Address uses pre-increment register values.
        unique case (mem_read)
          4'd1:    begin addr_d = pc_q;              start = 1'b1; end
          4'd2:    begin addr_d = ar_q;              start = 1'b1; end
          4'd3:    begin addr_d = {dp_q, ar_q[7:0]}; start = 1'b1; end
          4'd4:    begin addr_d = {a_q, b_q};        start = 1'b1; end
          default: ;
        endcase
        if (start) begin
          mask_d  = fetch[10:0];
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // Control inputs are deliberately ignored until the ack arrives.
        if (bus.mem_ack) begin
          if (mask_q[M_IR])  ir_d       = {8'h00, bus.mem_rdata};
          if (mask_q[M_ARL]) ar_d[7:0]  = bus.mem_rdata;
          if (mask_q[M_ARH]) ar_d[15:8] = bus.mem_rdata;
          if (mask_q[M_T])   t_d        = bus.mem_rdata;
          if (mask_q[M_A])   a_d        = bus.mem_rdata;
          if (mask_q[M_B])   b_d        = bus.mem_rdata;
          if (mask_q[M_XL])  x_d[7:0]   = bus.mem_rdata;
          if (mask_q[M_XH])  x_d[15:8]  = bus.mem_rdata;
          if (mask_q[M_YL])  y_d[7:0]   = bus.mem_rdata;
          if (mask_q[M_YH])  y_d[15:8]  = bus.mem_rdata;
          if (mask_q[M_DP])  dp_d       = bus.mem_rdata;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and register file update with synchronous reset.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      pc_q    <= '0;
      ar_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      ir_q    <= '0;
      t_q     <= '0;
      dp_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      x_q     <= x_d;
      y_q     <= y_d;
      ir_q    <= ir_d;
      t_q     <= t_d;
      dp_q    <= dp_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // busy tracks the outstanding request, so both come from the same flop.
  assign busy         = req_q;
  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign PC = pc_q;
  assign AR = ar_q;
  assign X  = x_q;
  assign Y  = y_q;
  assign IR = ir_q;
  assign T  = t_q;
  assign DP = dp_q;
  assign A  = a_q;
  assign B  = b_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Scoreboard bench for mem_fetch_unit: each command pushes its expected
// completion record; a negedge monitor pops and compares on each completion.
module tb_mem_fetch_unit;

  typedef struct {
    logic [15:0] addr;
    int          cycles;
    logic [15:0] pc, ar, x, y, ir;
    logic [7:0]  t, dp, a, b;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  mem_read = '0;
  logic [15:0] fetch = '0;
  logic        pc_inc = 1'b0;
  logic        busy;
  logic [15:0] PC, AR, X, Y, IR;
  logic [7:0]  T, DP, A, B;

  mem_fetch_unit_if bus ();

  mem_fetch_unit dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .fetch(fetch),
    .pc_inc(pc_inc), .busy(busy), .bus(bus),
    .PC(PC), .AR(AR), .X(X), .Y(Y), .IR(IR),
    .T(T), .DP(DP), .A(A), .B(B)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string tag, input exp_t e);
    check({tag, "_pc"}, {16'h0, PC}, {16'h0, e.pc});
    check({tag, "_ar"}, {16'h0, AR}, {16'h0, e.ar});
    check({tag, "_x"},  {16'h0, X},  {16'h0, e.x});
    check({tag, "_y"},  {16'h0, Y},  {16'h0, e.y});
    check({tag, "_ir"}, {16'h0, IR}, {16'h0, e.ir});
    check({tag, "_t"},  {24'h0, T},  {24'h0, e.t});
    check({tag, "_dp"}, {24'h0, DP}, {24'h0, e.dp});
    check({tag, "_a"},  {24'h0, A},  {24'h0, e.a});
    check({tag, "_b"},  {24'h0, B},  {24'h0, e.b});
  endtask

  // ---------------- memory model ----------------
  logic [7:0] mem [0:65535];
  int         wait_cfg = 0;
  int         wait_cnt = 0;
  logic       auto_ack = 1'b0;
  logic [7:0] auto_data = '0;
  logic       mem_auto = 1'b1;
  logic       manual_ack = 1'b0;
  logic [7:0] manual_data = '0;

  assign bus.mem_ack   = mem_auto ? auto_ack  : manual_ack;
  assign bus.mem_rdata = mem_auto ? auto_data : manual_data;

  // Acks a request after wait_cfg idle cycles, once per request.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      auto_ack <= (wait_cnt == wait_cfg);
      if (wait_cnt == wait_cfg) auto_data <= mem[bus.mem_addr];
      wait_cnt <= wait_cnt + 1;
    end else begin
      auto_ack <= 1'b0;
      wait_cnt <= 0;
    end
  end

  // ---------------- scoreboard monitor ----------------
  exp_t exp_q[$];
  logic expect_abort = 1'b0;
  int   busy_cnt = 0;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_cnt  = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy === 1'b1) begin
        busy_cnt++;
        if (!expect_abort) begin
          if (exp_q.size() == 0) check("unexpected_busy", 32'd1, 32'd0);
          else begin
            check("addr_hold", {16'h0, bus.mem_addr}, {16'h0, exp_q[0].addr});
            check("req_high", {31'h0, bus.mem_req}, 32'd1);
          end
        end
      end else if (prev_busy) begin
        if (!expect_abort) begin
          if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
          else begin
            e = exp_q.pop_front();
            check("busy_cycles", busy_cnt, e.cycles);
            check("done_addr", {16'h0, bus.mem_addr}, {16'h0, e.addr});
            check("done_req_low", {31'h0, bus.mem_req}, 32'd0);
            check_regs("done", e);
          end
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [3:0] mr, input logic [15:0] f, input logic inc, input int junk);
    @(negedge clk);
    mem_read = mr; fetch = f; pc_inc = inc;
    @(posedge clk);
    for (int i = 0; i < junk; i++) begin
      @(negedge clk);
      mem_read = 4'd2; fetch = 16'h07FF; pc_inc = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    mem_read = '0; fetch = '0; pc_inc = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("done_in_time", {31'h0, busy}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    e = '{addr: 16'h0, cycles: 1, pc: 16'h0, ar: 16'h0, x: 16'h0, y: 16'h0,
          ir: 16'h0, t: 8'h0, dp: 8'h0, a: 8'h0, b: 8'h0};

    mem[16'h0000] = 8'h86; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'h34;
    mem[16'h0003] = 8'h20; mem[16'h0004] = 8'h00; mem[16'h0005] = 8'h00;
    mem[16'h0006] = 8'h10; mem[16'h0007] = 8'hC3; mem[16'h0008] = 8'hEE;
    mem[16'h0009] = 8'h3C; mem[16'h000A] = 8'h99; mem[16'h0010] = 8'h77;
    mem[16'h1234] = 8'h5A; mem[16'h2000] = 8'h20;

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_regs("reset", e);
    check("reset_req", {31'h0, bus.mem_req}, 32'd0);
    check("reset_busy", {31'h0, busy}, 32'd0);
    check("reset_addr", {16'h0, bus.mem_addr}, 32'd0);

    // Opcode fetch from PC with increment, zero-wait memory.
    e.addr = 16'h0000; e.pc = 16'h0001; e.ir = 16'h0086;
    exp_q.push_back(e); issue(4'd1, 16'h0001, 1'b1, 0); wait_done();
    e.addr = 16'h0001; e.pc = 16'h0002; e.dp = 8'h12;
    exp_q.push_back(e); issue(4'd1, 16'h0400, 1'b1, 0); wait_done();
    e.addr = 16'h0002; e.pc = 16'h0003; e.ar = 16'h0034;
    exp_q.push_back(e); issue(4'd1, 16'h0002, 1'b1, 0); wait_done();

    // {DP,ARL} read into A and B with three wait cycles.
    wait_cfg = 3;
    e.addr = 16'h1234; e.cycles = 4; e.a = 8'h5A; e.b = 8'h5A;
    exp_q.push_back(e); issue(4'd3, 16'h0030, 1'b0, 0); wait_done();
    wait_cfg = 0; e.cycles = 1;

    e.addr = 16'h0003; e.pc = 16'h0004; e.ar = 16'h2034;
    exp_q.push_back(e); issue(4'd1, 16'h0004, 1'b1, 0); wait_done();
    e.addr = 16'h0004; e.pc = 16'h0005; e.ar = 16'h2000;
    exp_q.push_back(e); issue(4'd1, 16'h0002, 1'b1, 0); wait_done();
    // AR-addressed read loading ARH with 20.
    e.addr = 16'h2000; e.ar = 16'h2000;
    exp_q.push_back(e); issue(4'd2, 16'h0004, 1'b0, 0); wait_done();
    e.addr = 16'h0005; e.pc = 16'h0006; e.a = 8'h00;
    exp_q.push_back(e); issue(4'd1, 16'h0010, 1'b1, 0); wait_done();
    e.addr = 16'h0006; e.pc = 16'h0007; e.b = 8'h10;
    exp_q.push_back(e); issue(4'd1, 16'h0020, 1'b1, 0); wait_done();
    // {A,B}-addressed read into XL.
    e.addr = 16'h0010; e.x = 16'h0077;
    exp_q.push_back(e); issue(4'd4, 16'h0040, 1'b0, 0); wait_done();
    e.addr = 16'h0007; e.pc = 16'h0008; e.y = 16'hC300;
    exp_q.push_back(e); issue(4'd1, 16'h0200, 1'b1, 0); wait_done();
    // Dummy read: only ignored mask bits set.
    e.addr = 16'h0008; e.pc = 16'h0009;
    exp_q.push_back(e); issue(4'd1, 16'hF800, 1'b1, 0); wait_done();
    // Same byte into T, XH and YL.
    e.addr = 16'h0009; e.pc = 16'h000A; e.t = 8'h3C; e.x = 16'h3C77; e.y = 16'hC33C;
    exp_q.push_back(e); issue(4'd1, 16'h0188, 1'b1, 0); wait_done();

    // Control inputs toggled during REQ are ignored.
    wait_cfg = 2;
    e.addr = 16'h000A; e.cycles = 3; e.pc = 16'h000B; e.ir = 16'h0099;
    exp_q.push_back(e); issue(4'd1, 16'h0001, 1'b1, 2); wait_done();
    wait_cfg = 0; e.cycles = 1;

    // Select code 5 acts as none; pc_inc still applies.
    issue(4'd5, 16'h0001, 1'b1, 0);
    e.pc = 16'h000C;
    check("sel5_req", {31'h0, bus.mem_req}, 32'd0);
    check("sel5_busy", {31'h0, busy}, 32'd0);
    check_regs("sel5", e);

    // Ack while idle changes nothing.
    mem_auto = 1'b0; manual_data = 8'hFF; manual_ack = 1'b1;
    repeat (2) @(negedge clk);
    manual_ack = 1'b0;
    check("idle_ack_busy", {31'h0, busy}, 32'd0);
    check_regs("idle_ack", e);

    // Reset in REQ, then a late ack.
    expect_abort = 1'b1;
    issue(4'd1, 16'h0001, 1'b1, 0);
    check("abort_req_seen", {31'h0, bus.mem_req}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; manual_data = 8'hA5; manual_ack = 1'b1;
    @(negedge clk);
    manual_ack = 1'b0;
    e = '{addr: 16'h0, cycles: 1, pc: 16'h0, ar: 16'h0, x: 16'h0, y: 16'h0,
          ir: 16'h0, t: 8'h0, dp: 8'h0, a: 8'h0, b: 8'h0};
    check("abort_req", {31'h0, bus.mem_req}, 32'd0);
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_addr", {16'h0, bus.mem_addr}, 32'd0);
    check_regs("abort", e);
    repeat (2) @(negedge clk);
    check_regs("abort_late", e);
    expect_abort = 1'b0;

    // Unit is back in IDLE and accepts a fresh command.
    mem_auto = 1'b1;
    e.addr = 16'h0000; e.pc = 16'h0001; e.ir = 16'h0086;
    exp_q.push_back(e); issue(4'd1, 16'h0001, 1'b1, 0); wait_done();

    // PC wrap: 65534 increments from 0001 reach FFFF, one more wraps.
    @(negedge clk);
    pc_inc = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    pc_inc = 1'b0;
    check("pc_ffff", {16'h0, PC}, 32'h0000_FFFF);
    issue(4'd0, 16'h0000, 1'b1, 0);
    check("pc_wrap", {16'h0, PC}, 32'd0);
    check("wrap_req", {31'h0, bus.mem_req}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
